// File: rtl/seq_cla_sub.sv
// Sequential subtractor: computes a - b one 4-bit carry-lookahead slice per cycle,
// LSB slice first, with a valid/ready handshake on both operand and result sides.
module seq_cla_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;   // subtrahend is stored pre-inverted
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [3:0] slice_a, slice_b, slice_g, slice_p, slice_sum;
  logic [4:0] slice_c;

  // Operand slice selected by the nibble counter
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned k = 0; k < NumSlices; k++) begin
      if (cnt_q == CntW'(k)) begin
        slice_a = a_q[4*k +: 4];
        slice_b = nb_q[4*k +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice
  always_comb begin
    slice_g    = slice_a & slice_b;
    slice_p    = slice_a ^ slice_b;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0] | (slice_p[0] & slice_c[0]);
    slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0]) |
                 (slice_p[1] & slice_p[0] & slice_c[0]);
    slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1]) |
                 (slice_p[2] & slice_p[1] & slice_g[0]) |
                 (slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
    slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2]) |
                 (slice_p[3] & slice_p[2] & slice_g[1]) |
                 (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0]) |
                 (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & slice_c[0]);
    slice_sum  = slice_p ^ slice_c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        for (int unsigned k = 0; k < NumSlices; k++) begin
          if (cnt_q == CntW'(k)) begin
            res_d[4*k +: 4] = slice_sum;
          end
        end
        carry_d = slice_c[4];
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      nb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result and flags are forced to zero outside DONE
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = 1'b0;
    d         = '0;
    borrow    = 1'b0;
    ovf       = 1'b0;
    zero      = 1'b0;
    if (state_q == StDone) begin
      out_valid = 1'b1;
      d         = res_q;
      borrow    = ~carry_q;
      ovf       = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);
      zero      = (res_q == '0);
    end
  end

endmodule

// File: tb/tb_seq_cla_sub.sv
// Bench for seq_cla_sub at WIDTH 4, 16 and 64: directed cases on the 16-bit lane,
// then randomized traffic on all lanes checked every cycle against an arithmetic model.
module tb_seq_cla_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rand_go;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int w, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (w=%0d): got %0h expected %0h", nm, w, act, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic on W-bit operands
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                output logic [63:0] dd, output logic br, output logic ov,
                                output logic zr);
    logic [63:0] mask;
    logic signed [66:0] sa, sb, sd, half;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    half = 67'sd1 <<< (w - 1);
    sa = $signed({3'b000, av & mask});
    if (av[w-1]) sa = sa - (half <<< 1);
    sb = $signed({3'b000, bv & mask});
    if (bv[w-1]) sb = sb - (half <<< 1);
    sd = sa - sb;
    dd = (av - bv) & mask;
    br = (av & mask) < (bv & mask);
    ov = (sd >= half) || (sd < -half);
    zr = (dd == 64'd0);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W      = (g == 0) ? 4 : ((g == 1) ? 16 : 64);
    localparam int N      = W / 4;
    localparam int NumOps = (g == 0) ? 6000 : ((g == 1) ? 3000 : 1500);

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, d;
    logic         borrow, ovf, zero;
    logic         done;

    logic [63:0]  exp_d;
    logic         exp_b, exp_o, exp_z;
    logic         pending, started;
    int           t_acc, cyc, accepts;

    seq_cla_sub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .d        (d),
      .borrow   (borrow),
      .ovf      (ovf),
      .zero     (zero)
    );

    // Transaction-level model: one outstanding op, result due N+1 cycles after accept
    always @(posedge clk) begin
      logic [63:0] md;
      logic mb, mo, mz;
      if (rst) begin
        started <= 1'b1;
        pending <= 1'b0;
        cyc     <= 0;
        accepts <= 0;
      end else if (started === 1'b1) begin
        if (pending && (cyc >= t_acc + N + 1) && out_ready) begin
          pending <= 1'b0;
        end else if (!pending && in_valid) begin
          model(W, 64'(a), 64'(b), md, mb, mo, mz);
          exp_d   <= md;
          exp_b   <= mb;
          exp_o   <= mo;
          exp_z   <= mz;
          pending <= 1'b1;
          t_acc   <= cyc;
          accepts <= accepts + 1;
        end
        cyc <= cyc + 1;
      end
    end

    always @(negedge clk) begin
      if (started === 1'b1) begin
        chk("in_ready", W, 64'(in_ready), 64'(!pending));
        chk("out_valid", W, 64'(out_valid), 64'(pending && (cyc >= t_acc + N + 1)));
        if (pending && (cyc >= t_acc + N + 1)) begin
          chk("d", W, 64'(d), exp_d);
          chk("borrow", W, 64'(borrow), 64'(exp_b));
          chk("ovf", W, 64'(ovf), 64'(exp_o));
          chk("zero", W, 64'(zero), 64'(exp_z));
        end else begin
          chk("idle d", W, 64'(d), 64'd0);
          chk("idle flags", W, {61'd0, borrow, ovf, zero}, 64'd0);
        end
      end
    end

    function automatic logic [W-1:0] pick();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r = '0;
        1: r = '1;
        2: r = 64'd1 << (W - 1);
        3: r = r & 64'hF;
        default: ;
      endcase
      return r[W-1:0];
    endfunction

    // Operands are re-randomized every cycle so changes outside IDLE are exercised
    task automatic random_run();
      int guard;
      guard = 0;
      while (((accepts < NumOps) || pending) && (guard < NumOps * (N + 2) * 6)) begin
        @(negedge clk);
        #1;
        in_valid  = (accepts < NumOps) && ($urandom_range(0, 3) != 0);
        a         = pick();
        b         = pick();
        out_ready = ($urandom_range(0, 3) != 0);
        guard++;
      end
      chk("random run drained", W, 64'((accepts == NumOps) && !pending), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      done      = 1'b1;
    endtask

    if (g == 1) begin : g_drv
      initial begin
        done = 1'b0;
        directed();
        random_run();
      end
    end else begin : g_drv
      initial begin
        done      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        wait (rand_go === 1'b1);
        random_run();
      end
    end
  end

  task automatic wait_ready16(input string nm);
    int k;
    k = 0;
    while (lane[1].in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " in_ready"}, 16, 64'(lane[1].in_ready), 64'd1);
  endtask

  task automatic op16(input string nm, input logic [15:0] av, input logic [15:0] bv,
                      input logic [15:0] ed, input logic eb, input logic eo, input logic ez,
                      input bit hold);
    int lat;
    logic [15:0] dh;
    @(negedge clk);
    wait_ready16(nm);
    #1;
    lane[1].a         = av;
    lane[1].b         = bv;
    lane[1].in_valid  = 1'b1;
    lane[1].out_ready = !hold;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        lane[1].in_valid = 1'b0;
        lane[1].a        = ~av;
        lane[1].b        = av ^ 16'h5A5A;
      end
    end while (lane[1].out_valid !== 1'b1 && lat < 40);
    chk({nm, " latency"}, 16, 64'(lat), 64'd5);
    chk({nm, " d"}, 16, 64'(lane[1].d), 64'(ed));
    chk({nm, " borrow"}, 16, 64'(lane[1].borrow), 64'(eb));
    chk({nm, " ovf"}, 16, 64'(lane[1].ovf), 64'(eo));
    chk({nm, " zero"}, 16, 64'(lane[1].zero), 64'(ez));
    if (hold) begin
      dh = lane[1].d;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk({nm, " held d"}, 16, 64'(lane[1].d), 64'(dh));
        chk({nm, " held out_valid"}, 16, 64'(lane[1].out_valid), 64'd1);
        chk({nm, " held in_ready"}, 16, 64'(lane[1].in_ready), 64'd0);
      end
      #1 lane[1].out_ready = 1'b1;
      @(negedge clk);
      chk({nm, " release in_ready"}, 16, 64'(lane[1].in_ready), 64'd1);
      chk({nm, " release out_valid"}, 16, 64'(lane[1].out_valid), 64'd0);
    end
  endtask

  task automatic directed();
    int sent, nout;
    int tv [3];
    logic [15:0] dv [3];
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [15:0] te [3];
    ta = '{16'h1234, 16'hFFFF, 16'h7FFF};
    tb = '{16'h0234, 16'h0001, 16'hFFFF};
    te = '{16'h1000, 16'hFFFE, 16'h8000};
    tv = '{0, 0, 0};
    dv = '{16'h0, 16'h0, 16'h0};
    rand_go           = 1'b0;
    rst               = 1'b1;
    lane[1].in_valid  = 1'b0;
    lane[1].out_ready = 1'b0;
    lane[1].a         = '0;
    lane[1].b         = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 16, 64'(lane[1].in_ready), 64'd1);
    chk("reset out_valid", 16, 64'(lane[1].out_valid), 64'd0);
    chk("reset d", 16, 64'(lane[1].d), 64'd0);

    op16("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    op16("ripple borrow", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op16("signed ovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    op16("zero", 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    op16("backpressure", 16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset asserted during the second CALC cycle
    @(negedge clk);
    wait_ready16("abort");
    #1;
    lane[1].a         = 16'h1234;
    lane[1].b         = 16'h0001;
    lane[1].in_valid  = 1'b1;
    lane[1].out_ready = 1'b1;
    @(negedge clk);
    lane[1].in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort in_ready", 16, 64'(lane[1].in_ready), 64'd1);
    chk("abort out_valid", 16, 64'(lane[1].out_valid), 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort no result", 16, 64'(lane[1].out_valid), 64'd0);
    end
    op16("after reset", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    lane[1].out_ready = 1'b1;
    sent = 0;
    nout = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (lane[1].out_valid === 1'b1 && nout < 3) begin
        tv[nout] = c;
        dv[nout] = lane[1].d;
        nout++;
      end
      if (lane[1].in_ready === 1'b1) begin
        #1;
        if (sent < 3) begin
          lane[1].a        = ta[sent];
          lane[1].b        = tb[sent];
          lane[1].in_valid = 1'b1;
          sent++;
        end else begin
          lane[1].in_valid = 1'b0;
        end
      end
    end
    lane[1].in_valid = 1'b0;
    chk("b2b result count", 16, 64'(nout), 64'd3);
    for (int i = 0; i < 3; i++) chk("b2b d", 16, 64'(dv[i]), 64'(te[i]));
    chk("b2b spacing 0-1", 16, 64'(tv[1] - tv[0]), 64'd6);
    chk("b2b spacing 1-2", 16, 64'(tv[2] - tv[1]), 64'd6);
    rand_go = 1'b1;
  endtask

  initial begin
    int t;
    t = 0;
    while (!(lane[0].done === 1'b1 && lane[1].done === 1'b1 && lane[2].done === 1'b1) &&
           t < 90000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 90000) begin
      errors++;
      $display("FAIL timeout: lanes still busy after %0d cycles, limit 90000", t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_cla_sub.md
SEQ_CLA_SUB -- requirements
Module: seq_cla_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair a/b offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, WIDTH, minuend.
REQ-007 SHALL have port b, input, WIDTH, subtrahend.
REQ-008 SHALL have port out_valid, output, 1, result d and flags valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port d, output, WIDTH, difference a-b mod 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1, unsigned borrow; 1 when a<b unsigned.
REQ-012 SHALL have port ovf, output, 1, signed two's-complement overflow of a-b.
REQ-013 SHALL have port zero, output, 1, 1 when d==0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL accept operands in IDLE on in_valid=1; latch a, ~b and set carry register to 1; load nibble counter to 0; go to CALC.
REQ-017 SHALL compute in CALC one 4-bit slice per cycle, LSB slice first: slice k = a[4k+3:4k] + ~b[4k+3:4k] + carry, with a 4-bit carry-lookahead (generate/propagate) slice.
REQ-018 SHALL register each slice's 4 sum bits into result bit positions 4k+3..4k and its carry-out into the carry register.
REQ-019 SHALL leave CALC for DONE after slice WIDTH/4-1 completes; CALC lasts exactly WIDTH/4 cycles.
REQ-020 SHALL assert out_valid only in DONE; latency from acceptance edge to first out_valid cycle = WIDTH/4+1 cycles (5 at WIDTH=16).
REQ-021 SHALL drive borrow = NOT final carry-out in DONE.
REQ-022 SHALL drive ovf = (a[MSB] != b[MSB]) AND (d[MSB] != a[MSB]) in DONE, using latched operands.
REQ-023 SHALL drive zero = (d == 0) in DONE.
REQ-024 SHALL hold d, borrow, ovf, zero stable while out_valid=1 and out_ready=0 (backpressure, indefinitely).
REQ-025 SHALL return from DONE to IDLE on out_ready=1; in_ready rises the following cycle (no same-cycle accept/output overlap).
REQ-026 SHALL ignore in_valid, a, b outside IDLE; operands changing during CALC do not affect the result.
REQ-027 SHALL drive d, borrow, ovf, zero to 0 whenever out_valid=0.
REQ-028 SHALL sustain throughput of one result per WIDTH/4+2 cycles when in_valid and out_ready are held 1.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE, clear operand, result, carry and counter registers; out_valid=0, in_ready=1 the next cycle.
REQ-030 SHALL abort any CALC or DONE in progress on reset, discard the partial result and emit no out_valid for it.
REQ-031 SHALL give rst priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 SHALL verify basic: WIDTH=16, a=0x1234, b=0x0234 -> after 5 cycles d=0x1000, borrow=0, ovf=0, zero=0.
REQ-033 SHALL verify borrow and carry ripple across slices: a=0x0000, b=0x0001 -> d=0xFFFF, borrow=1, ovf=0, zero=0.
REQ-034 SHALL verify signed overflow and zero: a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, borrow=0; a=b=0xA5A5 -> d=0, zero=1.
REQ-035 SHALL verify backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL verify reset mid-CALC: rst at cycle 2 of CALC -> no out_valid, in_ready=1 next cycle, next operation a=5, b=3 gives d=2.
REQ-037 SHALL verify back-to-back: in_valid and out_ready held 1 for 3 operand pairs -> 3 correct results spaced 6 cycles apart; random compare vs a-b over 10k vectors at WIDTH=4, 16, 64.
